// File: rtl/mskaes_req_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : mskaes_req_arbiter
//  Description : Shares one masked AES-128 core and its PRNG between two
//                requesters. Sequences PRNG reseeds (start-up and every
//                RESEED_PERIOD encryptions), arbitrates round-robin, runs one
//                encryption at a time and returns the shared ciphertext
//                tagged with the requester index. Shares are only moved,
//                never combined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mskaes_req_arbiter #(
    parameter int d             = 2,
    parameter int RESEED_PERIOD = 16,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              nrst,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [128*d-1:0]  req0_sh_plaintext,
    input  logic [128*d-1:0]  req0_sh_key,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [128*d-1:0]  req1_sh_plaintext,
    input  logic [128*d-1:0]  req1_sh_key,
    // response
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [128*d-1:0]  rsp_sh_ciphertext,
    // AES core
    output logic              aes_valid_in,
    input  logic              aes_ready,
    output logic [128*d-1:0]  aes_sh_plaintext,
    output logic [128*d-1:0]  aes_sh_key,
    input  logic              aes_cipher_valid,
    input  logic [128*d-1:0]  aes_sh_ciphertext,
    // PRNG
    output logic              prng_start_reseed,
    input  logic              prng_out_valid
);

    localparam int W = 128 * d;
    localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(RESEED_PERIOD);

    typedef enum logic [2:0] {
        S_RESEED    = 3'd0,
        S_WAIT_PRNG = 3'd1,
        S_IDLE      = 3'd2,
        S_ISSUE     = 3'd3,
        S_BUSY      = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             aes_valid_q, aes_valid_d;
    logic             reseed_q, reseed_d;
    logic [W-1:0]     pt_q, pt_d;
    logic [W-1:0]     key_q, key_d;
    logic [W-1:0]     ct_q, ct_d;

    logic             grant0;
    logic             grant1;

    // Round-robin grant: on contention the requester not served last wins.
    assign grant0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || rr_last_q);
    assign grant1 = (state_q == S_IDLE) && req1_valid && (!req0_valid || !rr_last_q);

    assign req0_ready        = grant0;
    assign req1_ready        = grant1;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_id            = rsp_id_q;
    assign rsp_sh_ciphertext = ct_q;
    assign aes_valid_in      = aes_valid_q;
    assign aes_sh_plaintext  = pt_q;
    assign aes_sh_key        = key_q;
    assign prng_start_reseed = reseed_q;

    // Next-state and registered-output logic for the job sequencer.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        cnt_d       = cnt_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        aes_valid_d = 1'b0;
        reseed_d    = 1'b0;
        pt_d        = pt_q;
        key_d       = key_q;
        ct_d        = ct_q;
        unique case (state_q)
            S_RESEED: begin
                reseed_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT_PRNG;
            end
            S_WAIT_PRNG: begin
                // During the pulse cycle the PRNG has not yet seen the request,
                // so a still-high valid from the old seed must not count.
                if (prng_out_valid && !reseed_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (grant0 || grant1) begin
                    pt_d      = grant1 ? req1_sh_plaintext : req0_sh_plaintext;
                    key_d     = grant1 ? req1_sh_key       : req0_sh_key;
                    rsp_id_d  = grant1;
                    rr_last_d = grant1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (aes_ready) begin
                    aes_valid_d = 1'b1;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                // A result coincident with our own start pulse cannot be ours.
                if (aes_cipher_valid && !aes_valid_q) begin
                    ct_d        = aes_sh_ciphertext;
                    rsp_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (cnt_q == C_PERIOD) ? S_RESEED : S_IDLE;
                end
            end
            default: begin
                state_d = S_RESEED;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_RESEED;
            rr_last_q   <= 1'b1;
            cnt_q       <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            aes_valid_q <= 1'b0;
            reseed_q    <= 1'b0;
            pt_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            aes_valid_q <= aes_valid_d;
            reseed_q    <= reseed_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mskaes_req_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mskaes_req_arbiter
//  Description : Self-checking bench for mskaes_req_arbiter with behavioural
//                AES core and PRNG models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mskaes_req_arbiter;

    localparam int D   = 2;
    localparam int W   = 128 * D;
    localparam int LAT = 3;

    localparam logic [127:0] C_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] C_PT  = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] C_CT  = 128'h320b6a19978511dcfb09dc021d842539;

    logic         clk = 1'b0;
    logic         nrst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_sh_plaintext, req0_sh_key, req1_sh_plaintext, req1_sh_key;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_sh_ciphertext;
    logic         aes_valid_in, aes_ready, aes_cipher_valid;
    logic [W-1:0] aes_sh_plaintext, aes_sh_key, aes_sh_ciphertext;
    logic         prng_start_reseed, prng_out_valid;

    always #5 clk = ~clk;

    mskaes_req_arbiter #(.d(D), .RESEED_PERIOD(2), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_sh_plaintext(req0_sh_plaintext), .req0_sh_key(req0_sh_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_sh_plaintext(req1_sh_plaintext), .req1_sh_key(req1_sh_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sh_ciphertext(rsp_sh_ciphertext),
        .aes_valid_in(aes_valid_in), .aes_ready(aes_ready),
        .aes_sh_plaintext(aes_sh_plaintext), .aes_sh_key(aes_sh_key),
        .aes_cipher_valid(aes_cipher_valid), .aes_sh_ciphertext(aes_sh_ciphertext),
        .prng_start_reseed(prng_start_reseed), .prng_out_valid(prng_out_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] share(input logic [127:0] v, input logic [127:0] m);
        logic [W-1:0] s;
        for (int i = 0; i < 128; i++) begin
            s[2*i]   = m[i];
            s[2*i+1] = v[i] ^ m[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] unshare(input logic [W-1:0] s);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = s[2*i] ^ s[2*i+1];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_bits(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int cycles);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles, required event not seen", name, cycles);
    endtask

    // ---------------- PRNG model ----------------
    int prng_delay = 30;
    int prng_cnt   = 0;
    int pulse_wide = 0;
    logic prev_pulse = 1'b0;
    initial prng_out_valid = 1'b0;
    always @(negedge clk) begin
        if (prng_start_reseed) begin
            if (prev_pulse) pulse_wide++;
            prng_out_valid = 1'b0;
            prng_cnt       = prng_delay;
        end else if (prng_cnt > 0) begin
            prng_cnt--;
            if (prng_cnt == 0) prng_out_valid = 1'b1;
        end
        prev_pulse = prng_start_reseed;
    end

    // ---------------- AES core model ----------------
    int           core_cnt  = 0;
    logic         inject_cv = 1'b0;
    logic [W-1:0] core_res  = '0;
    initial begin
        aes_ready         = 1'b1;
        aes_cipher_valid  = 1'b0;
        aes_sh_ciphertext = '0;
    end
    always @(negedge clk) begin
        logic [127:0] p, k, c;
        aes_cipher_valid = inject_cv;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                aes_cipher_valid  = 1'b1;
                aes_sh_ciphertext = core_res;
                aes_ready         = 1'b1;
            end
        end
        if (aes_valid_in) begin
            p        = unshare(aes_sh_plaintext);
            k        = unshare(aes_sh_key);
            c        = (p == C_PT && k == C_KEY) ? C_CT : ~p;
            core_res = share(c, rnd128());
            core_cnt = LAT;
            aes_ready = 1'b0;
        end
    end

    // ---------------- job sequencing ----------------
    int model_cnt  = 0;
    int exp_pulses = 0;
    int pulses_seen = 0;
    logic [W-1:0] pt0_sh, key0_sh, pt1_sh, key1_sh;

    always @(posedge clk) begin
        #1;
        if (prng_start_reseed) pulses_seen++;
    end

    task automatic run_job(input logic v0, input logic v1, input logic exp_id, input int bp);
        int t;
        int bad;
        logic [W-1:0] hold_ct;
        logic         hold_id;
        @(negedge clk);
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = (bp == 0);
        #1;
        t = 0;
        while (!(req0_ready || req1_ready) && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 300) begin timeout("grant", t); return; end
        check_int("grant_onehot", int'({req1_ready, req0_ready}), exp_id ? 2 : 1);
        check_int("prng_valid_at_grant", int'(prng_out_valid), 1);
        t = 0;
        @(negedge clk);
        while (!aes_valid_in && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin timeout("aes_launch", t); return; end
        check_bits("aes_pt", aes_sh_plaintext, exp_id ? pt1_sh : pt0_sh);
        check_bits("aes_key", aes_sh_key, exp_id ? key1_sh : key0_sh);
        @(negedge clk);
        check_int("aes_pulse_width", int'(aes_valid_in), 0);
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin timeout("rsp_valid", t); return; end
        check_int("rsp_id", int'(rsp_id), int'(exp_id));
        check_bits("rsp_shares", rsp_sh_ciphertext, core_res);
        check_bits("rsp_recombined", {128'h0, unshare(rsp_sh_ciphertext)}, {128'h0, C_CT});
        if (bp > 0) begin
            hold_ct = rsp_sh_ciphertext;
            hold_id = rsp_id;
            bad = 0;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            repeat (bp) begin
                @(negedge clk); #1;
                if (!rsp_valid || rsp_id !== hold_id || rsp_sh_ciphertext !== hold_ct ||
                    req0_ready || req1_ready || aes_valid_in) bad++;
            end
            check_int("backpressure_stable", bad, 0);
            req0_valid = v0;
            req1_valid = v1;
            rsp_ready  = 1'b1;
        end
        @(posedge clk);
        model_cnt++;
        if (model_cnt == 2) begin
            model_cnt = 0;
            exp_pulses++;
            t = 0;
            @(negedge clk); #1;
            while (!prng_start_reseed && t < 6) begin @(negedge clk); #1; t++; end
            check_int("reseed_after_period", int'(prng_start_reseed), 1);
        end
    endtask

    typedef struct {
        logic v0;
        logic v1;
        logic exp_id;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int t;
        int bad;
        int p0;
        tbl[0] = '{1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b1};

        pt0_sh  = share(C_PT,  rnd128());
        key0_sh = share(C_KEY, rnd128());
        pt1_sh  = share(C_PT,  rnd128());
        key1_sh = share(C_KEY, rnd128());
        req0_sh_plaintext = pt0_sh;
        req0_sh_key       = key0_sh;
        req1_sh_plaintext = pt1_sh;
        req1_sh_key       = key1_sh;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        nrst       = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_int("reset_ctrl", int'({prng_start_reseed, rsp_valid, aes_valid_in,
                  req0_ready, req1_ready, rsp_id}), 0);
        check_bits("reset_rsp_data", rsp_sh_ciphertext, '0);
        check_bits("reset_aes_pt", aes_sh_plaintext, '0);
        check_bits("reset_aes_key", aes_sh_key, '0);

        // Start-up reseed, PRNG valid after 30 cycles, no requests
        p0 = pulses_seen;
        nrst = 1'b1;
        bad = 0;
        repeat (45) begin
            @(negedge clk);
            if (req0_ready || req1_ready || rsp_valid || aes_valid_in) bad++;
        end
        check_int("startup_reseed_pulses", pulses_seen - p0, 1);
        check_int("startup_quiet", bad, 0);
        check_int("startup_prng_valid", int'(prng_out_valid), 1);
        exp_pulses = 1;
        prng_delay = 5;

        // Arbitration table
        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].v0, tbl[i].v1, tbl[i].exp_id, 0);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Response back-pressure for 20 cycles
        run_job(1'b1, 1'b0, 1'b0, 20);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset while BUSY
        @(negedge clk);
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        t = 0;
        while (!req0_ready && t < 300) begin @(negedge clk); #1; t++; end
        if (t >= 300) timeout("rst_grant", t);
        @(negedge clk);
        req0_valid = 1'b0;
        t = 0;
        while (!aes_valid_in && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) timeout("rst_launch", t);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check_int("rst_busy_ctrl", int'({rsp_valid, aes_valid_in, prng_start_reseed}), 0);
        p0 = pulses_seen;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check_int("rst_busy_no_rsp", bad, 0);
        check_int("rst_busy_reseed", pulses_seen - p0, 1);
        exp_pulses++;
        model_cnt = 0;

        // Stray cipher_valid while IDLE
        @(posedge clk); #1 inject_cv = 1'b1;
        @(posedge clk); #1 inject_cv = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check_int("stray_cipher_ignored", bad, 0);

        // Recovery: rr_last back to 1, so requester 0 wins contention
        run_job(1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_int("total_reseed_pulses", pulses_seen, exp_pulses);
        check_int("reseed_pulse_width", pulse_wide, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
